mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 210 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage: turns ex_mem load/store requests into single bus transactions,
// stalls the pipeline while waiting for ack, and aborts on misalignment or timeout.
module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] store_data_i,
  input  logic [4:0]  reg_write_addr_i,
  input  logic        reg_write_en_i,
  input  logic [31:0] reg_write_data_i,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [31:0] data_addr_o,
  output logic [3:0]  data_sel_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_ack_i,
  input  logic [31:0] data_rdata_i,
  output logic [4:0]  reg_write_addr_o,
  output logic        reg_write_en_o,
  output logic [31:0] reg_write_data_o,
  output logic        stallreq_o,
  output logic        addr_err_o,
  output logic        bus_err_o
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  // Access size code: 0 none, 1 byte, 2 half, 3 word
  function automatic logic [1:0] op_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd6: op_size = 2'd1;
      4'd3, 4'd4, 4'd7: op_size = 2'd2;
      4'd5, 4'd8:       op_size = 2'd3;
      default:          op_size = 2'd0;
    endcase
  endfunction

  state_e       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         req_q, req_d, we_q, we_d;
  logic [31:0]  addr_q, addr_d, wdata_q, wdata_d, alu_q, alu_d;
  logic [3:0]   sel_q, sel_d, op_q, op_d;
  logic [1:0]   off_q, off_d;
  logic [4:0]   rda_q, rda_d;
  logic         rde_q, rde_d;

  logic [1:0]   size_in, size_lat;
  logic         aligned, is_store;
  logic [3:0]   sel_c;
  logic [31:0]  wdata_c, load_c;
  logic [7:0]   lane_b;
  logic [15:0]  lane_h;

  // Decode of the incoming instruction
  always_comb begin
    size_in  = op_size(mem_op_i);
    is_store = (mem_op_i == 4'd6) || (mem_op_i == 4'd7) || (mem_op_i == 4'd8);
    aligned  = 1'b1;
    sel_c    = 4'b1111;
    wdata_c  = store_data_i;
    case (size_in)
      2'd1: begin
        sel_c   = 4'b1000 >> mem_addr_i[1:0];
        wdata_c = {4{store_data_i[7:0]}};
      end
      2'd2: begin
        aligned = ~mem_addr_i[0];
        sel_c   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
        wdata_c = {2{store_data_i[15:0]}};
      end
      2'd3: aligned = (mem_addr_i[1:0] == 2'b00);
      default: ;
    endcase
  end

  // Big-endian lane extraction for the latched load
  always_comb begin
    size_lat = op_size(op_q);
    case (off_q)
      2'd0:    lane_b = data_rdata_i[31:24];
      2'd1:    lane_b = data_rdata_i[23:16];
      2'd2:    lane_b = data_rdata_i[15:8];
      default: lane_b = data_rdata_i[7:0];
    endcase
    lane_h = off_q[1] ? data_rdata_i[15:0] : data_rdata_i[31:16];
    case (size_lat)
      2'd1:    load_c = (op_q == 4'd1) ? {{24{lane_b[7]}}, lane_b} : {24'b0, lane_b};
      2'd2:    load_c = (op_q == 4'd3) ? {{16{lane_h[15]}}, lane_h} : {16'b0, lane_h};
      default: load_c = data_rdata_i;
    endcase
  end

  // Next-state and combinational write-back / handshake outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    off_d   = off_q;
    rda_d   = rda_q;
    rde_d   = rde_q;
    alu_d   = alu_q;
    reg_write_addr_o = reg_write_addr_i;
    reg_write_en_o   = reg_write_en_i;
    reg_write_data_o = reg_write_data_i;
    stallreq_o       = 1'b0;
    addr_err_o       = 1'b0;
    bus_err_o        = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i && size_in != 2'd0) begin
          reg_write_en_o = 1'b0;
          if (!aligned) begin
            addr_err_o = 1'b1;
          end else begin
            stallreq_o = 1'b1;
            state_d    = BUSY;
            cnt_d      = '0;
            req_d      = 1'b1;
            we_d       = is_store;
            addr_d     = {mem_addr_i[31:2], 2'b00};
            sel_d      = sel_c;
            wdata_d    = wdata_c;
            op_d       = mem_op_i;
            off_d      = mem_addr_i[1:0];
            rda_d      = reg_write_addr_i;
            rde_d      = reg_write_en_i;
            alu_d      = reg_write_data_i;
          end
        end
      end
      BUSY: begin
        reg_write_addr_o = rda_q;
        reg_write_en_o   = 1'b0;
        reg_write_data_o = alu_q;
        if (data_ack_i) begin
          reg_write_en_o   = rde_q;
          reg_write_data_o = we_q ? alu_q : load_c;
          state_d          = IDLE;
          req_d            = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          bus_err_o = 1'b1;
          state_d   = IDLE;
          req_d     = 1'b0;
        end else begin
          stallreq_o = 1'b1;
          cnt_d      = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset silences every combinational output immediately
    if (rst) begin
      reg_write_addr_o = '0;
      reg_write_en_o   = 1'b0;
      reg_write_data_o = '0;
      stallreq_o       = 1'b0;
      addr_err_o       = 1'b0;
      bus_err_o        = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      op_q    <= '0;
      off_q   <= '0;
      rda_q   <= '0;
      rde_q   <= 1'b0;
      alu_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      off_q   <= off_d;
      rda_q   <= rda_d;
      rde_q   <= rde_d;
      alu_q   <= alu_d;
    end
  end

  assign data_req_o   = req_q;
  assign data_we_o    = we_q;
  assign data_addr_o  = addr_q;
  assign data_sel_o   = sel_q;
  assign data_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a transaction-level reference model.
module tb_mem_stage;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i, store_data_i, reg_write_data_i, data_rdata_i;
  logic [4:0]  reg_write_addr_i;
  logic        reg_write_en_i, data_ack_i;
  logic        data_req_o, data_we_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic [3:0]  data_sel_o;
  logic [4:0]  reg_write_addr_o;
  logic        reg_write_en_o;
  logic [31:0] reg_write_data_o;
  logic        stallreq_o, addr_err_o, bus_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .mem_op_i(mem_op_i),
    .mem_addr_i(mem_addr_i), .store_data_i(store_data_i),
    .reg_write_addr_i(reg_write_addr_i), .reg_write_en_i(reg_write_en_i),
    .reg_write_data_i(reg_write_data_i), .data_req_o(data_req_o),
    .data_we_o(data_we_o), .data_addr_o(data_addr_o), .data_sel_o(data_sel_o),
    .data_wdata_o(data_wdata_o), .data_ack_i(data_ack_i),
    .data_rdata_i(data_rdata_i), .reg_write_addr_o(reg_write_addr_o),
    .reg_write_en_o(reg_write_en_o), .reg_write_data_o(reg_write_data_o),
    .stallreq_o(stallreq_o), .addr_err_o(addr_err_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: bytes touched, lanes, replicated store data, extracted load
  function automatic int nbytes(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd6: return 1;
      4'd3, 4'd4, 4'd7: return 2;
      4'd5, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic logic [3:0] exp_sel(input int off, input int nb);
    logic [3:0] s = '0;
    for (int k = off; k < off + nb; k++) s[3-k] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [3:0] op, input logic [31:0] sd);
    if (nbytes(op) == 1) return {24'b0, sd[7:0]} * 32'h0101_0101;
    if (nbytes(op) == 2) return {16'b0, sd[15:0]} * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] exp_load(input logic [3:0] op, input int off, input logic [31:0] rd);
    logic [63:0] v = '0;
    int nb = nbytes(op);
    for (int k = 0; k < nb; k++) v = (v << 8) | 64'(rd[8*(3-(off+k)) +: 8]);
    if ((op == 4'd1 || op == 4'd3) && v[8*nb-1]) v = v - (64'd1 << (8*nb));
    return v[31:0];
  endfunction

  task automatic do_op(input logic v, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] sd, input logic [4:0] wa, input logic we,
                       input logic [31:0] wd, input int ack_at, input logic [31:0] rd,
                       input logic ack_early);
    int nb = nbytes(op);
    int off = int'(addr[1:0]);
    logic store = (op >= 4'd6) && (op <= 4'd8);
    @(negedge clk);
    valid_i = v; mem_op_i = op; mem_addr_i = addr; store_data_i = sd;
    reg_write_addr_i = wa; reg_write_en_i = we; reg_write_data_i = wd;
    data_ack_i = ack_early; data_rdata_i = rd;
    #1;
    if (!v || nb == 0) begin
      check("pass_addr", 32'(reg_write_addr_o), 32'(wa));
      check("pass_en", 32'(reg_write_en_o), 32'(we));
      check("pass_data", reg_write_data_o, wd);
      check("pass_stall", 32'(stallreq_o), 0);
      @(posedge clk); #1;
      check("pass_req", 32'(data_req_o), 0);
      return;
    end
    if (off % nb != 0) begin
      check("mis_aerr", 32'(addr_err_o), 1);
      check("mis_en", 32'(reg_write_en_o), 0);
      check("mis_stall", 32'(stallreq_o), 0);
      @(posedge clk); #1;
      check("mis_req", 32'(data_req_o), 0);
      return;
    end
    check("acc_stall", 32'(stallreq_o), 1);
    check("acc_aerr", 32'(addr_err_o), 0);
    @(posedge clk); #1;
    check("busy_req", 32'(data_req_o), 1);
    check("busy_we", 32'(data_we_o), 32'(store));
    check("busy_addr", data_addr_o, {addr[31:2], 2'b00});
    check("busy_sel", 32'(data_sel_o), 32'(exp_sel(off, nb)));
    if (store) check("busy_wdata", data_wdata_o, exp_wdata(op, sd));
    for (int i = 0; i < int'(TO); i++) begin
      @(negedge clk);
      valid_i = 1'($urandom); mem_op_i = 4'($urandom); mem_addr_i = $urandom;
      data_ack_i = (i == ack_at);
      #1;
      check("hold_req", 32'(data_req_o), 1);
      check("hold_addr", data_addr_o, {addr[31:2], 2'b00});
      if (i == ack_at) begin
        check("ack_stall", 32'(stallreq_o), 0);
        check("ack_berr", 32'(bus_err_o), 0);
        check("ack_en", 32'(reg_write_en_o), 32'(we));
        check("ack_addr", 32'(reg_write_addr_o), 32'(wa));
        check("ack_data", reg_write_data_o, store ? wd : exp_load(op, off, rd));
      end else if (i == int'(TO) - 1) begin
        check("to_berr", 32'(bus_err_o), 1);
        check("to_en", 32'(reg_write_en_o), 0);
        check("to_stall", 32'(stallreq_o), 0);
      end else begin
        check("wait_stall", 32'(stallreq_o), 1);
        check("wait_berr", 32'(bus_err_o), 0);
      end
      @(posedge clk); #1;
      if (i == ack_at || i == int'(TO) - 1) begin
        check("end_req", 32'(data_req_o), 0);
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; mem_op_i = '0; mem_addr_i = '0; store_data_i = '0;
    reg_write_addr_i = 5'd7; reg_write_en_i = 1'b1; reg_write_data_i = 32'hDEAD_BEEF;
    data_ack_i = 1'b0; data_rdata_i = '0;
    #12;
    check("rst_req", 32'(data_req_o), 0);
    check("rst_addr", data_addr_o, 0);
    check("rst_sel", 32'(data_sel_o), 0);
    check("rst_en", 32'(reg_write_en_o), 0);
    check("rst_data", reg_write_data_o, 0);
    check("rst_stall", 32'(stallreq_o), 0);
    @(negedge clk); rst = 1'b0;

    // Directed scenarios
    do_op(1'b1, 4'd0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234_5678, 0, 32'h0, 1'b1);
    do_op(1'b1, 4'd1, 32'h101, 32'h0, 5'd3, 1'b1, 32'h0, 2, 32'h11F0_2233, 1'b1);
    do_op(1'b1, 4'd7, 32'h202, 32'h0000_ABCD, 5'd0, 1'b0, 32'h55, 0, 32'h0, 1'b0);
    do_op(1'b1, 4'd5, 32'h103, 32'h0, 5'd9, 1'b1, 32'h0, 0, 32'h0, 1'b0);
    do_op(1'b1, 4'd5, 32'h400, 32'h0, 5'd9, 1'b1, 32'h0, int'(TO), 32'h0, 1'b0);
    do_op(1'b1, 4'd2, 32'h103, 32'h0, 5'd1, 1'b1, 32'h0, int'(TO) - 1, 32'h0000_0080, 1'b0);
    do_op(1'b1, 4'd3, 32'h402, 32'h0, 5'd2, 1'b1, 32'h0, 1, 32'h1234_8001, 1'b0);

    // Reset in the middle of a pending access
    @(negedge clk);
    valid_i = 1'b1; mem_op_i = 4'd5; mem_addr_i = 32'h800; data_ack_i = 1'b0;
    @(posedge clk); #1;
    check("mid_req_pre", 32'(data_req_o), 1);
    #2; rst = 1'b1; #1;
    check("mid_req", 32'(data_req_o), 0);
    check("mid_stall", 32'(stallreq_o), 0);
    check("mid_berr", 32'(bus_err_o), 0);
    check("mid_en", 32'(reg_write_en_o), 0);
    @(negedge clk); rst = 1'b0; valid_i = 1'b0; data_ack_i = 1'b1;
    reg_write_en_i = 1'b1; reg_write_data_i = 32'hCAFE_0001; #1;
    check("late_ack_data", reg_write_data_o, 32'hCAFE_0001);
    check("late_ack_berr", 32'(bus_err_o), 0);
    @(posedge clk); #1;
    check("late_ack_req", 32'(data_req_o), 0);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      do_op(1'($urandom_range(0, 7) != 0), 4'($urandom_range(0, 10)), $urandom, $urandom,
            5'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, TO)), $urandom,
            1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
